// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Requester/transmitter bundle for the shared-UART arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [3:0]  gnt;
  logic [7:0]  tx_dout;
  logic        tx_dout_vld;
  logic        tx_busy;
  logic        arb_err;

  // master: requesters plus transmitter side; slave: the arbiter itself
  modport master (
    output req, req_data, req_last, tx_busy,
    input  req_ack, gnt, tx_dout, tx_dout_vld, arb_err
  );

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output req_ack, gnt, tx_dout, tx_dout_vld, arb_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Packet-granular 4-way arbiter feeding one 8N1 UART transmitter.
//            Define UART_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int START_TO = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int CW = $clog2(START_TO) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(START_TO - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [1:0]         owner, owner_d;
  logic [1:0]         rr_ptr, rr_d;
  logic               last_r, last_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [7:0]         dout_q, dout_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;

  logic [1:0]         base, idx, sel;
  logic               found;
  logic               byte_done, release_gnt;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign base = 2'd0;
`else
  assign base = rr_ptr;
`endif

  // First requester at or after base, wrapping modulo 4
  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = base + i[1:0];
      if (!found && bus.req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    rr_d        = rr_ptr;
    last_d      = last_r;
    cnt_d       = cnt;
    gnt_d       = gnt_q;
    ack_d       = '0;
    dout_d      = dout_q;
    vld_d       = 1'b0;
    err_d       = 1'b0;
    byte_done   = 1'b0;
    release_gnt = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          owner_d = sel;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[owner]) begin
          release_gnt = 1'b1;
        end else if (!bus.tx_busy) begin
          dout_d  = bus.req_data[{owner, 3'b000} +: 8];
          vld_d   = 1'b1;
          ack_d   = gnt_q;
          last_d  = bus.req_last[owner];
          cnt_d   = '0;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt >= TO_LAST) begin
          // Transmitter never started: flag it and move on as if sent
          err_d     = 1'b1;
          byte_done = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) byte_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      if (last_r) release_gnt = 1'b1;
      else        state_d     = GRANT;
    end

    if (release_gnt) begin
      gnt_d   = '0;
      state_d = IDLE;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_d    = owner + 2'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= 2'd0;
      rr_ptr <= 2'd0;
      last_r <= 1'b0;
      cnt    <= '0;
      gnt_q  <= '0;
      ack_q  <= '0;
      dout_q <= 8'h00;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      rr_ptr <= rr_d;
      last_r <= last_d;
      cnt    <= cnt_d;
      gnt_q  <= gnt_d;
      ack_q  <= ack_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.req_ack     = ack_q;
  assign bus.tx_dout     = dout_q;
  assign bus.tx_dout_vld = vld_q;
  assign bus.arb_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.N_REQ(4), .START_TO(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transmitter frame: busy one cycle after the strobe, then idle
  task automatic frame();
    bus.tx_busy = 1'b1;
    tick();
    bus.tx_busy = 1'b0;
    tick();
  endtask

  task automatic chk_strobe(input string tag, input logic [7:0] d, input logic [3:0] a);
    chk({tag, "_vld"}, bus.tx_dout_vld, 1'b1);
    chk({tag, "_dout"}, bus.tx_dout, d);
    chk({tag, "_ack"}, bus.req_ack, a);
  endtask

  initial begin
    logic [3:0] exp_g;
    bus.req      = 4'b0000;
    bus.req_data = 32'h0;
    bus.req_last = 4'b0000;
    bus.tx_busy  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_vld", bus.tx_dout_vld, 1'b0);
    chk("rst_dout", bus.tx_dout, 8'h00);
    chk("rst_ack", bus.req_ack, 4'b0000);
    chk("rst_err", bus.arb_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single packet on requester 2
    bus.req = 4'b0100;
    bus.req_data[23:16] = 8'hA5;
    bus.req_last = 4'b1111;
    tick();
    chk("single_gnt", bus.gnt, 4'b0100);
    chk("single_novld", bus.tx_dout_vld, 1'b0);
    tick();
    chk_strobe("single", 8'hA5, 4'b0100);
    bus.req = 4'b0000;
    bus.tx_busy = 1'b1;
    tick();
    chk("single_vld_pulse", bus.tx_dout_vld, 1'b0);
    chk("single_ack_pulse", bus.req_ack, 4'b0000);
    tick();
    tick();
    chk("single_hold_gnt", bus.gnt, 4'b0100);
    chk("single_hold_dout", bus.tx_dout, 8'hA5);
    bus.tx_busy = 1'b0;
    tick();
    chk("single_release", bus.gnt, 4'b0000);

    // rr_ptr now 3: requester 3 wins over 0 (fixed priority: 0 wins)
    bus.req = 4'b1001;
    bus.req_data = 32'h3000_0010;
    tick();
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b1000;
`endif
    chk("rr3_gnt", bus.gnt, exp_g);
    bus.req = 4'b0000;
    tick();
    chk("rr3_abandon", bus.gnt, 4'b0000);

    // Contention from reset, one-byte packets
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    bus.req_data = 32'hA3A2_A1A0;
    bus.req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % 4);
`endif
      tick();
      chk($sformatf("cont%0d_gnt", k), bus.gnt, exp_g);
      tick();
      chk($sformatf("cont%0d_ack", k), bus.req_ack, exp_g);
      chk($sformatf("cont%0d_dout", k), bus.tx_dout,
          (exp_g == 4'b0001) ? 8'hA0 : (exp_g == 4'b0010) ? 8'hA1 :
          (exp_g == 4'b0100) ? 8'hA2 : 8'hA3);
      frame();
      chk($sformatf("cont%0d_rel", k), bus.gnt, 4'b0000);
    end
    bus.req = 4'b0000;
    tick();

    // Multi-byte lock: requester 1 sends three bytes while 0 waits
    bus.req = 4'b0010;
    bus.req_data = 32'h0000_1155;
    bus.req_last = 4'b0001;
    tick();
    chk("multi_gnt", bus.gnt, 4'b0010);
    bus.req = 4'b0011;
    tick();
    chk_strobe("multi_b0", 8'h11, 4'b0010);
    bus.req_data[15:8] = 8'h22;
    frame();
    chk("multi_lock1", bus.gnt, 4'b0010);
    tick();
    chk_strobe("multi_b1", 8'h22, 4'b0010);
    bus.req_data[15:8] = 8'h33;
    bus.req_last = 4'b0011;
    frame();
    chk("multi_lock2", bus.gnt, 4'b0010);
    tick();
    chk_strobe("multi_b2", 8'h33, 4'b0010);
    bus.req = 4'b0001;
    frame();
    chk("multi_rel", bus.gnt, 4'b0000);
    tick();
    chk("multi_next", bus.gnt, 4'b0001);
    tick();
    chk_strobe("multi_r0", 8'h55, 4'b0001);
    bus.req = 4'b0000;
    frame();

    // Start timeout, last byte
    bus.req = 4'b0100;
    bus.req_data = 32'h00C3_0000;
    bus.req_last = 4'b1111;
    tick();
    chk("to1_gnt", bus.gnt, 4'b0100);
    tick();
    chk_strobe("to1", 8'hC3, 4'b0100);
    bus.req = 4'b0000;
    for (int k = 0; k < 7; k++) tick();
    chk("to1_noerr", bus.arb_err, 1'b0);
    tick();
    chk("to1_err", bus.arb_err, 1'b1);
    chk("to1_rel", bus.gnt, 4'b0000);
    tick();
    chk("to1_errpulse", bus.arb_err, 1'b0);

    // Start timeout, not last: returns to GRANT for the next byte
    bus.req = 4'b1000;
    bus.req_data = 32'h3C00_0000;
    bus.req_last = 4'b0000;
    tick();
    chk("to0_gnt", bus.gnt, 4'b1000);
    tick();
    chk_strobe("to0", 8'h3C, 4'b1000);
    bus.req_data[31:24] = 8'h4D;
    bus.req_last = 4'b1000;
    for (int k = 0; k < 8; k++) tick();
    chk("to0_err", bus.arb_err, 1'b1);
    chk("to0_keep", bus.gnt, 4'b1000);
    tick();
    chk_strobe("to0_b1", 8'h4D, 4'b1000);
    bus.req = 4'b0000;
    frame();
    chk("to0_rel", bus.gnt, 4'b0000);

    // Abandon in GRANT, then rr_ptr = owner+1
    bus.req = 4'b0010;
    bus.req_last = 4'b1111;
    tick();
    chk("ab_gnt", bus.gnt, 4'b0010);
    bus.req = 4'b0000;
    tick();
    chk("ab_rel", bus.gnt, 4'b0000);
    chk("ab_novld", bus.tx_dout_vld, 1'b0);
    bus.req = 4'b0101;
    bus.req_data = 32'h0077_0066;
    tick();
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b0100;
`endif
    chk("ab_next", bus.gnt, exp_g);
    bus.req = 4'b0000;
    tick();

    // Busy already high in IDLE: grant, then stall until busy falls
    bus.tx_busy = 1'b1;
    bus.req = 4'b0001;
    bus.req_data = 32'h0000_0099;
    tick();
    chk("bz_gnt", bus.gnt, 4'b0001);
    tick();
    chk("bz_stall", bus.tx_dout_vld, 1'b0);
    bus.tx_busy = 1'b0;
    tick();
    chk_strobe("bz", 8'h99, 4'b0001);
    bus.req = 4'b0000;
    frame();

    // Async reset in WAIT_DONE
    bus.req = 4'b0001;
    bus.req_data = 32'h0000_00E1;
    tick();
    tick();
    chk_strobe("ar", 8'hE1, 4'b0001);
    bus.req = 4'b0000;
    bus.tx_busy = 1'b1;
    tick();
    chk("ar_pre_gnt", bus.gnt, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", bus.gnt, 4'b0000);
    chk("ar_vld", bus.tx_dout_vld, 1'b0);
    chk("ar_dout", bus.tx_dout, 8'h00);
    tick();
    rst_n = 1'b1;
    bus.req = 4'b0001;
    tick();
    chk("ar_regnt", bus.gnt, 4'b0001);
    bus.tx_busy = 1'b0;
    tick();
    chk_strobe("ar_post", 8'hE1, 4'b0001);
    bus.req = 4'b0000;
    frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
